// File: rtl/instr_queue_pkg.sv
// Shared types for the instruction queue.
//   IQ_DEPTH   : default entry count of the queue
//   word32_t   : one fetched instruction word
//   iq_entry_t : one stored queue entry (speculation flag, epoch tag, instruction)
package instr_queue_pkg;

  localparam int IQ_DEPTH = 8;

  typedef logic [31:0] word32_t;

  typedef struct packed {
    logic    spec;
    logic    epoch;
    word32_t instr;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch (writer) and decode/dispatch (reader).
// Holds instructions fetched past one unresolved predicted branch.
// When the branch resolves as mispredicted, those wrong-path entries are dropped
// from the tail.
// Ports:
//   clk_i, reset_i                      clock, asynchronous active-high reset
//   iq_write_i, instr_i                 fetch write strobe and instruction
//   issuing_branch_i                    the current write is a predicted branch
//   cond_eval_i, corr_pred_i            branch resolution and its outcome
//   iq_full_o                           queue holds DEPTH entries (stalls fetch)
//   deq_valid_o, deq_ready_i            head handshake toward dispatch
//   deq_instr_o                         head instruction (0 while empty)
//   count_o                             occupancy
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             iq_write_i,
  input  logic [31:0]      instr_i,
  input  logic             issuing_branch_i,
  input  logic             cond_eval_i,
  input  logic             corr_pred_i,
  output logic             iq_full_o,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [31:0]      deq_instr_o,
  output logic [CNT_W-1:0] count_o
);

  iq_entry_t        mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;
  logic             spec_active_q, spec_active_d;
  logic             epoch_q, epoch_d;

  iq_entry_t        head_entry;
  logic             full, empty;
  logic             head_spec;
  logic             resolve, squash;
  logic             deq_valid;
  logic             wr_en, rd_en, wr_spec;
  logic [CNT_W-1:0] squash_amt;

  always_comb begin
    head_entry = mem_q[head_q];
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);

    // Speculative entries always form the youngest spec_cnt entries, so the
    // head is speculative only when every queued entry is. This also guards
    // against the one-bit epoch aliasing after two correct resolutions while
    // an old entry is still queued.
    head_spec  = ~empty & head_entry.spec & (head_entry.epoch == epoch_q)
               & (count_q == spec_cnt_q);

    resolve    = cond_eval_i & spec_active_q;
    squash     = resolve & ~corr_pred_i;

    deq_valid  = ~empty & ~(squash & head_spec);
    rd_en      = deq_valid & deq_ready_i;
    wr_en      = iq_write_i & ~full;
    wr_spec    = wr_en & spec_active_q & ~cond_eval_i & ~issuing_branch_i;

    squash_amt = squash ? spec_cnt_q : '0;

    head_d     = head_q + PTR_W'(rd_en);
    // A full squash of DEPTH entries truncates to zero, leaving the tail in place.
    tail_d     = tail_q + PTR_W'(wr_en) - squash_amt[PTR_W-1:0];
    count_d    = count_q + CNT_W'(wr_en) - CNT_W'(rd_en) - squash_amt;

    if (resolve) begin
      spec_cnt_d = '0;
    end else begin
      spec_cnt_d = spec_cnt_q + CNT_W'(wr_spec) - CNT_W'(rd_en & head_spec);
    end

    spec_active_d = (wr_en & issuing_branch_i) | (spec_active_q & ~cond_eval_i);
    // Flipping the epoch retires every stored spec bit at once on a correct prediction.
    epoch_d       = epoch_q ^ (resolve & corr_pred_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      spec_cnt_q    <= '0;
      spec_active_q <= 1'b0;
      epoch_q       <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      spec_cnt_q    <= spec_cnt_d;
      spec_active_q <= spec_active_d;
      epoch_q       <= epoch_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[tail_q] <= '{spec: wr_spec, epoch: epoch_q, instr: instr_i};
    end
  end

  assign iq_full_o   = full;
  assign deq_valid_o = deq_valid;
  assign deq_instr_o = empty ? '0 : head_entry.instr;
  assign count_o     = count_q;

  // Interface protocol expected from fetch and the branch ALU.
  a_no_write_on_squash : assert property (@(posedge clk_i) disable iff (reset_i)
    squash |-> !iq_write_i);
  a_one_branch : assert property (@(posedge clk_i) disable iff (reset_i)
    (iq_write_i && issuing_branch_i) |-> !(spec_active_q && !cond_eval_i));
  a_eval_when_spec : assert property (@(posedge clk_i) disable iff (reset_i)
    cond_eval_i |-> spec_active_q);

endmodule
